fp_demux_dispatch: RTL and testbench

- 1-to-2 stream dispatcher. It is the splitting counterpart of the 2:1 operand mux.
- Takes one stream of IEEE-754 single-precision words with a valid/ready handshake and routes each word to one of two downstream FP units, chosen by select S.
- Each output has a one-entry register slice, so ready paths are isolated per unit.
- Also keeps per-output completed-transfer counters for debug and performance readout.

---
 rtl/fp_demux_dispatch.sv | 181 ++++++++++++++++++
 tb/tb_fp_demux_dispatch.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_demux_dispatch.sv
// Purpose : 1-to-2 dispatcher routing an IEEE-754 single word stream to one of two FP units by select s.
// Latency : 1 cycle from accepting edge to outk_valid/outk_data; per-output one-entry register slice.
// Backpres: in_ready depends only on the selected slot (empty or draining this cycle); slots stall independently.
// Optional: define FP_DISPATCH_NAN_FILTER_EN to discard NaN words (nan_drop pulses); default build forwards NaNs.

module fp_demux_dispatch #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             s,

    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,

    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data,

    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
    output logic             busy,
    output logic             nan_drop
);

    // Each output slot is either holding a word for its unit or idle.
    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    slot_state_e      slot0_state_q, slot0_state_d;
    slot_state_e      slot1_state_q, slot1_state_d;
    logic [WIDTH-1:0] slot0_data_q,  slot0_data_d;
    logic [WIDTH-1:0] slot1_data_q,  slot1_data_d;
    logic [CNT_W-1:0] cnt0_q,        cnt0_d;
    logic [CNT_W-1:0] cnt1_q,        cnt1_d;

    logic in_nan;
    logic drain0;
    logic drain1;
    logic slot0_rdy;
    logic slot1_rdy;
    logic accept;
    logic load0;
    logic load1;

    // NaN classification: all-ones exponent with a non-zero mantissa. Infinities pass.
`ifdef FP_DISPATCH_NAN_FILTER_EN
    always_comb begin
        in_nan = (in_data[30:23] == 8'hFF) && (in_data[22:0] != 23'd0);
    end
`else
    always_comb begin
        in_nan = 1'b0;
    end
`endif

    // Handshake decode: a slot can take a word if it is empty or is being drained this cycle.
    // A filtered NaN is swallowed without touching any slot, so it never has to wait.
    always_comb begin
        drain0    = (slot0_state_q == SLOT_FULL) && out0_ready;
        drain1    = (slot1_state_q == SLOT_FULL) && out1_ready;
        slot0_rdy = (slot0_state_q == SLOT_EMPTY) || drain0;
        slot1_rdy = (slot1_state_q == SLOT_EMPTY) || drain1;
        in_ready  = in_nan || (s ? slot1_rdy : slot0_rdy);
        accept    = in_valid && in_ready;
        load0     = accept && !in_nan && !s;
        load1     = accept && !in_nan &&  s;
    end

    // Slot 0 next state: load wins over drain so a simultaneous drain+load keeps the slot full.
    always_comb begin
        slot0_state_d = slot0_state_q;
        slot0_data_d  = slot0_data_q;
        case (slot0_state_q)
            SLOT_EMPTY: begin
                if (load0) begin
                    slot0_state_d = SLOT_FULL;
                    slot0_data_d  = in_data;
                end
            end
            SLOT_FULL: begin
                if (load0) begin
                    slot0_data_d  = in_data;
                end else if (drain0) begin
                    slot0_state_d = SLOT_EMPTY;
                end
            end
            default: begin
                slot0_state_d = SLOT_EMPTY;
            end
        endcase
    end

    // Slot 1 next state: same rules as slot 0, fully independent of it.
    always_comb begin
        slot1_state_d = slot1_state_q;
        slot1_data_d  = slot1_data_q;
        case (slot1_state_q)
            SLOT_EMPTY: begin
                if (load1) begin
                    slot1_state_d = SLOT_FULL;
                    slot1_data_d  = in_data;
                end
            end
            SLOT_FULL: begin
                if (load1) begin
                    slot1_data_d  = in_data;
                end else if (drain1) begin
                    slot1_state_d = SLOT_EMPTY;
                end
            end
            default: begin
                slot1_state_d = SLOT_EMPTY;
            end
        endcase
    end

    // Completed-transfer counters; they wrap naturally at 2^CNT_W.
    always_comb begin
        cnt0_d = cnt0_q + {{(CNT_W-1){1'b0}}, drain0};
        cnt1_d = cnt1_q + {{(CNT_W-1){1'b0}}, drain1};
    end

    // Slot and counter registers; reset discards any held words immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0_state_q <= SLOT_EMPTY;
            slot1_state_q <= SLOT_EMPTY;
            slot0_data_q  <= '0;
            slot1_data_q  <= '0;
            cnt0_q        <= '0;
            cnt1_q        <= '0;
        end else begin
            slot0_state_q <= slot0_state_d;
            slot1_state_q <= slot1_state_d;
            slot0_data_q  <= slot0_data_d;
            slot1_data_q  <= slot1_data_d;
            cnt0_q        <= cnt0_d;
            cnt1_q        <= cnt1_d;
        end
    end

`ifdef FP_DISPATCH_NAN_FILTER_EN
    logic nan_drop_q, nan_drop_d;

    // One-cycle pulse after the edge that swallowed a NaN.
    always_comb begin
        nan_drop_d = accept && in_nan;
    end

    // NaN drop pulse register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nan_drop_q <= 1'b0;
        end else begin
            nan_drop_q <= nan_drop_d;
        end
    end

    assign nan_drop = nan_drop_q;
`else
    assign nan_drop = 1'b0;
`endif

    assign out0_valid = (slot0_state_q == SLOT_FULL);
    assign out1_valid = (slot1_state_q == SLOT_FULL);
    assign out0_data  = slot0_data_q;
    assign out1_data  = slot1_data_q;
    assign cnt0       = cnt0_q;
    assign cnt1       = cnt1_q;
    assign busy       = out0_valid || out1_valid;

endmodule

// File: tb/tb_fp_demux_dispatch.sv
// Bench for fp_demux_dispatch: each output slot is modelled as a one-deep queue,
// counters as plain 8-bit sums, and every cycle's outputs are compared against it.
// Directed sequences pin the model with literal expectations, then random traffic runs.

module tb_fp_demux_dispatch;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        s;
    logic        out0_valid;
    logic        out0_ready;
    logic [31:0] out0_data;
    logic        out1_valid;
    logic        out1_ready;
    logic [31:0] out1_data;
    logic [7:0]  cnt0;
    logic [7:0]  cnt1;
    logic        busy;
    logic        nan_drop;

    int checks;
    int failures;

    // Reference model state
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [7:0]  mcnt0;
    logic [7:0]  mcnt1;
    bit          mnan;

    fp_demux_dispatch #(.WIDTH(32), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .s          (s),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data),
        .cnt0       (cnt0),
        .cnt1       (cnt1),
        .busy       (busy),
        .nan_drop   (nan_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_is_filtered_nan(input logic [31:0] d);
`ifdef FP_DISPATCH_NAN_FILTER_EN
        return (d[30:23] == 8'hFF) && (d[22:0] != 23'd0);
`else
        return 1'b0;
`endif
    endfunction

    // Registered outputs against the model's current state.
    task automatic compare_outputs();
        check("out0_valid", {31'd0, out0_valid}, {31'd0, q0.size() != 0});
        check("out1_valid", {31'd0, out1_valid}, {31'd0, q1.size() != 0});
        if (q0.size() != 0) check("out0_data", out0_data, q0[0]);
        if (q1.size() != 0) check("out1_data", out1_data, q1[0]);
        check("cnt0", {24'd0, cnt0}, {24'd0, mcnt0});
        check("cnt1", {24'd0, cnt1}, {24'd0, mcnt1});
        check("busy", {31'd0, busy}, {31'd0, (q0.size() != 0) || (q1.size() != 0)});
        check("nan_drop", {31'd0, nan_drop}, {31'd0, mnan});
    endtask

    // One clock cycle: drive at negedge, compare, advance the model across the next posedge.
    task automatic step(input bit v, input bit sel, input logic [31:0] d,
                        input bit r0, input bit r1, output bit rdy_seen);
        bit nanw;
        bit exp_rdy;
        bit acc;
        @(negedge clk);
        in_valid   = v;
        s          = sel;
        in_data    = d;
        out0_ready = r0;
        out1_ready = r1;
        #1;
        nanw    = model_is_filtered_nan(d);
        exp_rdy = nanw || (sel ? (q1.size() == 0 || r1) : (q0.size() == 0 || r0));
        check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        compare_outputs();
        rdy_seen = in_ready;
        acc = v && exp_rdy;
        if (q0.size() != 0 && r0) begin
            void'(q0.pop_front());
            mcnt0 = mcnt0 + 8'd1;
        end
        if (q1.size() != 0 && r1) begin
            void'(q1.pop_front());
            mcnt1 = mcnt1 + 8'd1;
        end
        mnan = acc && nanw;
        if (acc && !nanw) begin
            if (sel) q1.push_back(d);
            else     q0.push_back(d);
        end
        @(posedge clk);
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        mcnt0 = 8'd0;
        mcnt1 = 8'd0;
        mnan  = 1'b0;
    endtask

    bit          rdy;
    logic [31:0] rword;

    initial begin
        checks     = 0;
        failures   = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = 32'd0;
        s          = 1'b0;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #2;
        check("rst_out0_valid", {31'd0, out0_valid}, 32'd0);
        check("rst_out1_valid", {31'd0, out1_valid}, 32'd0);
        check("rst_out0_data", out0_data, 32'd0);
        check("rst_out1_data", out1_data, 32'd0);
        check("rst_cnt0", {24'd0, cnt0}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // First word to output 0, then drain it
        step(1'b1, 1'b0, 32'h3F800000, 1'b0, 1'b0, rdy);
        check("first_in_ready", {31'd0, rdy}, 32'd1);
        #2;
        check("first_out0_valid", {31'd0, out0_valid}, 32'd1);
        check("first_out0_data", out0_data, 32'h3F800000);
        check("first_out1_valid", {31'd0, out1_valid}, 32'd0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, rdy);
        #2;
        check("first_cnt0", {24'd0, cnt0}, 32'd1);
        check("first_out0_empty", {31'd0, out0_valid}, 32'd0);

        // Backpressure on output 1 does not block output 0
        step(1'b1, 1'b1, 32'h40000000, 1'b1, 1'b0, rdy);
        check("bp_first_rdy", {31'd0, rdy}, 32'd1);
        step(1'b1, 1'b1, 32'h40400000, 1'b1, 1'b0, rdy);
        check("bp_stall_rdy", {31'd0, rdy}, 32'd0);
        #2;
        check("bp_hold_data", out1_data, 32'h40000000);
        step(1'b1, 1'b0, 32'h3F000000, 1'b1, 1'b0, rdy);
        check("bp_other_rdy", {31'd0, rdy}, 32'd1);
        step(1'b1, 1'b1, 32'h40400000, 1'b1, 1'b1, rdy);
        check("bp_release_rdy", {31'd0, rdy}, 32'd1);
        #2;
        check("bp_second_data", out1_data, 32'h40400000);
        check("bp_cnt1", {24'd0, cnt1}, 32'd1);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, rdy);
        #2;
        check("bp_cnt0", {24'd0, cnt0}, 32'd2);
        check("bp_cnt1_final", {24'd0, cnt1}, 32'd2);

        // Streaming with alternating select: never stalls
        for (int i = 0; i < 10; i++) begin
            step(1'b1, i[0], 32'h41000000 + i, 1'b1, 1'b1, rdy);
            check("stream_rdy", {31'd0, rdy}, 32'd1);
        end
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, rdy);
        #2;
        check("stream_cnt0", {24'd0, cnt0}, 32'd7);
        check("stream_cnt1", {24'd0, cnt1}, 32'd7);

        // Fill both slots and stall them, then async reset between edges
        step(1'b1, 1'b0, 32'hC0000000, 1'b0, 1'b0, rdy);
        step(1'b1, 1'b1, 32'hC0400000, 1'b0, 1'b0, rdy);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_out0_valid", {31'd0, out0_valid}, 32'd0);
        check("arst_out1_valid", {31'd0, out1_valid}, 32'd0);
        check("arst_cnt0", {24'd0, cnt0}, 32'd0);
        check("arst_cnt1", {24'd0, cnt1}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_out0_data", out0_data, 32'd0);
        model_reset();
        #1;
        in_valid   = 1'b1;
        s          = 1'b0;
        in_data    = 32'h3FC00000;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        rst_n      = 1'b1;
        #1;
        check("post_rst_rdy", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        q0.push_back(32'h3FC00000);
        #2;
        check("post_rst_out0_valid", {31'd0, out0_valid}, 32'd1);
        check("post_rst_out0_data", out0_data, 32'h3FC00000);

        // Counter wrap: 256 completed transfers on output 0 from zero
        for (int i = 0; i < 255; i++) begin
            step(1'b1, 1'b0, 32'h00010000 + i, 1'b1, 1'b0, rdy);
        end
        #2;
        check("wrap_cnt0_255", {24'd0, cnt0}, 32'd255);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, rdy);
        #2;
        check("wrap_cnt0_0", {24'd0, cnt0}, 32'd0);
        check("wrap_cnt1_0", {24'd0, cnt1}, 32'd0);

`ifdef FP_DISPATCH_NAN_FILTER_EN
        // NaN swallowed even with slot 0 stalled; Inf forwarded
        step(1'b1, 1'b0, 32'h11111111, 1'b0, 1'b0, rdy);
        step(1'b1, 1'b0, 32'h7FC00000, 1'b0, 1'b0, rdy);
        check("nan_rdy", {31'd0, rdy}, 32'd1);
        #2;
        check("nan_drop_pulse", {31'd0, nan_drop}, 32'd1);
        check("nan_out0_hold", out0_data, 32'h11111111);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, rdy);
        #2;
        check("nan_drop_end", {31'd0, nan_drop}, 32'd0);
        step(1'b1, 1'b1, 32'h7F800000, 1'b0, 1'b0, rdy);
        #2;
        check("inf_out1_data", out1_data, 32'h7F800000);
        check("inf_out1_valid", {31'd0, out1_valid}, 32'd1);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, rdy);
`else
        // NaN forwarded as an ordinary word
        step(1'b1, 1'b0, 32'h7FC00000, 1'b1, 1'b1, rdy);
        check("nan_fwd_rdy", {31'd0, rdy}, 32'd1);
        #2;
        check("nan_fwd_data", out0_data, 32'h7FC00000);
        check("nan_drop_tied", {31'd0, nan_drop}, 32'd0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, rdy);
`endif

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 7))
                0:       rword = {$urandom_range(0, 1) == 1, 8'hFF, 23'($urandom_range(1, 32'h7FFFFF))};
                1:       rword = {$urandom_range(0, 1) == 1, 8'hFF, 23'd0};
                default: rword = $urandom;
            endcase
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, rword,
                 $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, rdy);
        end
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, rdy);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, rdy);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
